// File: rtl/mips_muldiv_if.sv
// Core-side bus of the MIPS multiply/divide unit: request, operands, HI/LO moves and results.
interface mips_muldiv_if #(
    parameter int WIDTH = 32
) ();
    logic             clk_enable;
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] rs_content;
    logic [WIDTH-1:0] rt_content;
    logic             mthi;
    logic             mtlo;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output clk_enable, start, op, rs_content, rt_content, mthi, mtlo,
        input  busy, done, hi, lo
    );

    modport slave (
        input  clk_enable, start, op, rs_content, rt_content, mthi, mtlo,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mips_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine owning HI/LO.
// Define MULDIV_FAST_MULT_EN to compute multiplies in a single cycle.
//
// state | meaning
// IDLE  | waiting for start; accepts mthi/mtlo
// RUN   | one shift-add or shift-subtract step per enabled cycle
// FIX   | sign correction, write HI/LO, pulse done
module mips_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic          clk_i,
    input  logic          reset_i,
    mips_muldiv_if.slave  bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   mag_q, mag_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               psign_q, psign_d;
    logic               rsign_q, rsign_d;
    logic               dz_q, dz_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    logic               signed_op;
    logic [WIDTH-1:0]   abs_rs, abs_rt;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign signed_op = ~bus.op[0];
    assign abs_rs = (signed_op && bus.rs_content[WIDTH-1]) ? -bus.rs_content : bus.rs_content;
    assign abs_rt = (signed_op && bus.rt_content[WIDTH-1]) ? -bus.rt_content : bus.rt_content;

    // Multiply: acc = {partial, multiplier}, add into the top half then shift right.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mag_q};
    assign mul_next = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};

    // Divide: acc = {remainder, dividend/quotient}; a borrow in bit WIDTH means restore.
    assign div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, mag_q};
    assign div_next  = div_trial[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                        : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

    // A zero divisor leaves |rs| in the remainder, so the sign fix restores rs exactly.
    assign prod_fix = psign_q ? -acc_q : acc_q;
    assign quo_fix  = dz_q ? {WIDTH{1'b1}}
                           : (psign_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
    assign rem_fix  = rsign_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

`ifdef MULDIV_FAST_MULT_EN
    logic [2*WIDTH-1:0] fast_prod;
    assign fast_prod = {{WIDTH{1'b0}}, abs_rs} * {{WIDTH{1'b0}}, abs_rt};
`endif

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        mag_d   = mag_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        psign_d = psign_q;
        rsign_d = rsign_q;
        dz_d    = dz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = done_q;
        if (bus.clk_enable) begin
            done_d = 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        op_d    = bus.op;
                        psign_d = signed_op & (bus.rs_content[WIDTH-1] ^ bus.rt_content[WIDTH-1]);
                        rsign_d = signed_op & bus.rs_content[WIDTH-1];
                        dz_d    = (bus.rt_content == '0);
                        cnt_d   = '0;
                        if (bus.op[1]) begin
                            mag_d   = abs_rt;
                            acc_d   = {{WIDTH{1'b0}}, abs_rs};
                            state_d = RUN;
                        end else begin
`ifdef MULDIV_FAST_MULT_EN
                            acc_d   = fast_prod;
                            state_d = FIX;
`else
                            mag_d   = abs_rs;
                            acc_d   = {{WIDTH{1'b0}}, abs_rt};
                            state_d = RUN;
`endif
                        end
                    end else begin
                        if (bus.mthi) hi_d = bus.rs_content;
                        if (bus.mtlo) lo_d = bus.rs_content;
                    end
                end
                RUN: begin
                    acc_d = op_q[1] ? div_next : mul_next;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIX;
                end
                FIX: begin
                    if (op_q[1]) begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end else begin
                        {hi_d, lo_d} = prod_fix;
                    end
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            op_q    <= '0;
            mag_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            psign_q <= 1'b0;
            rsign_q <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            mag_q   <= mag_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            psign_q <= psign_d;
            rsign_q <= rsign_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy = (state_q != IDLE);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Scoreboard bench for mips_muldiv_unit: stimulus queues expected HI/LO, latency and busy length;
// a negedge monitor pops and compares on every done pulse.
module tb_mips_muldiv_unit;
    localparam int W = 32;
    localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;
`ifdef MULDIV_FAST_MULT_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
        int          busy;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   busy_cnt = 0;
    exp_t sb[$];

    mips_muldiv_if #(.WIDTH(W)) bus ();

    mips_muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: counts busy samples and checks every done pulse against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                busy_cnt = 0;
            end else begin
                if (bus.busy) busy_cnt++;
                if (bus.done) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_done", 64'(bus.done), 64'd0);
                    end else begin
                        e = sb.pop_front();
                        chk({e.name, "_hi"}, 64'(bus.hi), 64'(e.hi));
                        chk({e.name, "_lo"}, 64'(bus.lo), 64'(e.lo));
                        chk({e.name, "_done_cycle"}, 64'(cyc), 64'(e.cyc));
                        chk({e.name, "_busy_cycles"}, 64'(busy_cnt), 64'(e.busy));
                    end
                    busy_cnt = 0;
                end
            end
        end
    end

    // Called #1 after a posedge; returns #1 after the start-sample edge.
    task automatic issue(input string name, input logic [1:0] op, input logic [31:0] rs,
                         input logic [31:0] rt, input logic [31:0] ehi, input logic [31:0] elo,
                         input int stall);
        exp_t e;
        int lat;
        lat = (FAST && !op[1]) ? 1 : W + 1;
        e.name = name; e.hi = ehi; e.lo = elo;
        e.cyc  = cyc + 1 + lat + stall;
        e.busy = lat + stall;
        sb.push_back(e);
        bus.start = 1'b1; bus.op = op; bus.rs_content = rs; bus.rt_content = rt;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.rs_content = 32'h0; bus.rt_content = 32'h0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
        chk("drain_pending", 64'(sb.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic move(input logic hi_en, input logic lo_en, input logic [31:0] v);
        bus.mthi = hi_en; bus.mtlo = lo_en; bus.rs_content = v;
        @(posedge clk); #1;
        bus.mthi = 1'b0; bus.mtlo = 1'b0; bus.rs_content = 32'h0;
    endtask

    initial begin
        logic [1:0] alt_op;
        alt_op = FAST ? DIVU : MULTU;
        bus.clk_enable = 1'b1; bus.start = 1'b0; bus.op = 2'b00;
        bus.rs_content = '0; bus.rt_content = '0; bus.mthi = 1'b0; bus.mtlo = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_hi", 64'(bus.hi), 64'd0);
        chk("rst_lo", 64'(bus.lo), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        @(posedge clk); #1;

        issue("multu_max", MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0);
        drain();
        issue("mult_neg", MULT, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 0);
        drain();
        issue("mult_minmin", MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 0);
        drain();
        issue("div_neg", DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 0);
        drain();
        issue("div_negdivisor", DIV, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 0);
        drain();
        issue("divu_zero", DIVU, 32'd100, 32'd0, 32'h00000064, 32'hFFFFFFFF, 0);
        drain();
        issue("div_zero_neg", DIV, 32'hFFFFFFF0, 32'd0, 32'hFFFFFFF0, 32'hFFFFFFFF, 0);
        drain();
        issue("div_min_m1", DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 0);
        drain();

        move(1'b1, 1'b1, 32'h12345678);
        chk("mthilo_hi", 64'(bus.hi), 64'h12345678);
        chk("mthilo_lo", 64'(bus.lo), 64'h12345678);
        move(1'b1, 1'b0, 32'h0BADF00D);
        chk("mthi_only_hi", 64'(bus.hi), 64'h0BADF00D);
        chk("mthi_only_lo", 64'(bus.lo), 64'h12345678);

        issue("divu_ignore", DIVU, 32'd9, 32'd4, 32'd1, 32'd2, 0);
        repeat (4) @(posedge clk);
        #1;
        bus.start = 1'b1; bus.op = MULTU; bus.rs_content = 32'hDEAD; bus.rt_content = 32'd3;
        bus.mthi = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.mthi = 1'b0; bus.rs_content = '0; bus.rt_content = '0;
        chk("busy_mthi_ignored", 64'(bus.hi), 64'h0BADF00D);
        drain();

        issue("stall", alt_op, alt_op[1] ? 32'd15 : 32'd3, alt_op[1] ? 32'd1 : 32'd5,
              32'd0, 32'd15, 10);
        repeat (5) @(posedge clk);
        #1 bus.clk_enable = 1'b0;
        repeat (10) @(posedge clk);
        #1 bus.clk_enable = 1'b1;
        drain();

        move(1'b1, 1'b1, 32'hA5A5A5A5);
        chk("pre_abort_hi", 64'(bus.hi), 64'hA5A5A5A5);
        bus.start = 1'b1; bus.op = FAST ? DIV : MULT;
        bus.rs_content = 32'd5; bus.rt_content = 32'd7;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (11) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_hi", 64'(bus.hi), 64'd0);
        chk("abort_lo", 64'(bus.lo), 64'd0);
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_done", 64'(bus.done), 64'd0);
        repeat (40) @(posedge clk);
        #1;
        chk("abort_lo_after", 64'(bus.lo), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mips_muldiv_unit.md
Name: mips_muldiv_unit

Overview:
- Parametrised, multi-cycle multiply/divide unit owning the HI and LO architectural registers for the MIPS core.
- Replaces the single-cycle combinational HI/LO path with an iterative engine:
  - shift-add for MULT/MULTU;
  - restoring division for DIV/DIVU.
- Supports MTHI/MTLO writes.
- Sits beside the ALU. The core stalls on busy before issuing MFHI/MFLO or another mul/div.

Parameters:
- WIDTH, 32, operand and HI/LO register width in bits; must be ≥4 and even.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- clk_enable  in  1  when low, all state holds, including done.
- start  in  1  request a mul/div; sampled only in IDLE.
- op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- rs_content  in  WIDTH  multiplicand or dividend.
- rt_content  in  WIDTH  multiplier or divisor.
- mthi  in  1  write rs_content into HI.
- mtlo  in  1  write rs_content into LO.
- busy  out  1  operation in flight.
- done  out  1  one-cycle pulse; HI/LO hold the new result.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (synchronous, clk_enable ignored): state goes to IDLE; hi=0, lo=0, busy=0, done=0. Reset mid-operation aborts; no partial result is written.
- States: IDLE, RUN, FIX. All transitions require clk_enable=1.
- IDLE:
  - start=1: latch op and operand magnitudes. Signed ops take the absolute value with WIDTH-bit unsigned interpretation, so |MIN_INT| = 2^(WIDTH-1).
  - Latch the result-sign flags:
    - product sign = sign(rs) XOR sign(rt);
    - quotient sign = sign(rs) XOR sign(rt);
    - remainder sign = sign(rs).
  - Then set count=0, go to RUN, busy=1.
  - start=0 with mthi/mtlo: write HI and/or LO. Both may be written in the same cycle.
  - start has priority over mthi/mtlo in the same cycle; the moves are dropped.
- RUN: one iteration per enabled edge; count increments.
  - Multiply: 2*WIDTH accumulator, shift-add.
  - Divide: restoring shift-subtract.
  - After the WIDTH-th iteration (count = WIDTH-1 at the edge), go to FIX.
- FIX: apply sign correction. On the edge:
  - write hi/lo;
  - busy=0, done=1;
  - go to IDLE.
- done falls at the next enabled edge.
- Latency: start-sample edge E0; done=1 and results visible after edge E(WIDTH+1). busy is high for WIDTH+1 cycles.
- Results:
  - Multiply: {hi,lo} = full 2*WIDTH product.
  - Divide: lo = quotient truncated toward zero; hi = remainder with the dividend's sign.
  - Divide by zero (signed or unsigned): lo = all ones, hi = rs_content. Run the normal WIDTH+1 latency; no fault.
  - DIV of MIN_INT by −1: lo = MIN_INT, hi = 0.
- Inputs while busy:
  - start, mthi and mtlo are ignored.
  - Operands are only sampled at E0 and may change afterwards.
- hi/lo change only on the FIX edge, on mthi/mtlo, or on reset.

Optional Feature:
- Macro: MULDIV_FAST_MULT_EN.
- Defined: MULT/MULTU compute the full product in one cycle. IDLE goes directly to FIX, so done is visible after E1 and busy is high for 1 cycle. DIV/DIVU are unchanged.
- Undefined: all ops are iterative as above.

Test Plan (WIDTH=32, feature off unless noted):
- MULTU with rs=0xFFFFFFFF, rt=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001; done pulses after E33; busy is high for 33 cycles. With MULDIV_FAST_MULT_EN defined, the same result appears after E1.
- MULT with rs=0xFFFFFFFD (−3), rt=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB. DIV with rs=0xFFFFFFF9 (−7), rt=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU with rs=100, rt=0 → lo=0xFFFFFFFF, hi=0x00000064. DIV with rs=0x80000000, rt=0xFFFFFFFF → lo=0x80000000, hi=0.
- mthi=1 and mtlo=1 with rs=0x12345678 in IDLE → hi=lo=0x12345678 next cycle. Then start a DIVU 9/4; a second start plus mthi at cycle 5 are ignored; final result is lo=2, hi=1.
- Start a MULTU 3×5; hold clk_enable=0 for 10 cycles mid-run → done is delayed by exactly 10 cycles; result is lo=15, hi=0.
- Start a MULT; assert reset at cycle 12 → next cycle hi=lo=0, busy=0, done=0; no done pulse follows.
